// File: rtl/display_pkg.sv
// Types and constants shared between the stopwatch counter and the seven-segment display.
package display_pkg;

  localparam int unsigned DisplayWidth = 14;

  typedef logic [DisplayWidth-1:0] display_number_t;

  localparam display_number_t DISPLAY_MAX = display_number_t'(9999);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } sw_state_e;

  // Saturating increment; the count must never wrap past the ceiling.
  function automatic display_number_t sat_inc(display_number_t n, display_number_t ceiling);
    return (n < ceiling) ? n + 1'b1 : ceiling;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw push-button, filters bounces and emits a one-cycle press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sync;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_prev_q;

  assign sync = sync_q[1];

  // The counter only runs while the synchronised level disagrees with the accepted one, so any
  // bounce back to the accepted level restarts the stability window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = sync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b00;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn_raw};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level       = level_q;
  assign press_pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Centisecond stopwatch: debounced start/stop and clear buttons, tick prescaler and run FSM.
module stopwatch_counter
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_COUNT       = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [13:0] number,
  output logic        running,
  output logic        overflow
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(Div - 1);
  localparam display_number_t MaxNum = display_number_t'(MAX_COUNT);

  logic ss_pulse, clr_pulse;
  logic ss_level, clr_level;
  logic unused_levels;

  assign unused_levels = ss_level ^ clr_level;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ss_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_start_stop),
    .level      (ss_level),
    .press_pulse(ss_pulse)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_clear),
    .level      (clr_level),
    .press_pulse(clr_pulse)
  );

  sw_state_e       state_q, state_d;
  display_number_t number_q, number_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            tick;

  assign tick = (state_q == StRun) && (presc_q == PreLast);

  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    presc_d  = presc_q;
    if (clr_pulse) begin
      state_d  = StIdle;
      number_d = '0;
      presc_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_pulse) state_d = StRun;
        end
        StRun: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (ss_pulse) state_d = StPause;
          // A saturating tick overrides a simultaneous pause request.
          if (tick) begin
            if (number_q < MaxNum) begin
              number_d = sat_inc(number_q, MaxNum);
            end else begin
              state_d = StDone;
            end
          end
        end
        StPause: begin
          if (ss_pulse) state_d = StRun;
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      number_q <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      presc_q  <= presc_d;
    end
  end

  assign number   = number_q;
  assign running  = (state_q == StRun);
  assign overflow = (state_q == StDone);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomised and directed checks of stopwatch_counter against a cycle-level behavioural model.
module tb_stopwatch_counter;

  localparam int Div  = 10;
  localparam int Deb  = 4;
  localparam int MaxC = 25;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MDone  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [13:0] number;
  logic        running;
  logic        overflow;

  always #5 clk = ~clk;

  stopwatch_counter #(
    .CLK_HZ         (1000),
    .TICK_HZ        (100),
    .DEBOUNCE_CYCLES(Deb),
    .MAX_COUNT      (MaxC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start_stop(btn_ss),
    .btn_clear     (btn_clr),
    .number        (number),
    .running       (running),
    .overflow      (overflow)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: state, count, run cycles since last tick, and per-button sample history.
  int m_state;
  int m_num;
  int m_phase;
  bit m_sync1 [2];
  bit m_sync2 [2];
  bit m_lvl   [2];
  bit m_lvl_old [2];
  bit m_win   [2][Deb];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_num   = 0;
    m_phase = 0;
    for (int b = 0; b < 2; b++) begin
      m_sync1[b]   = 1'b0;
      m_sync2[b]   = 1'b0;
      m_lvl[b]     = 1'b0;
      m_lvl_old[b] = 1'b0;
      for (int i = 0; i < Deb; i++) m_win[b][i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit ss_p, clr_p, tick, all_new;
    ss_p  = m_lvl[0] && !m_lvl_old[0];
    clr_p = m_lvl[1] && !m_lvl_old[1];
    if (clr_p) begin
      m_state = MIdle;
      m_num   = 0;
      m_phase = 0;
    end else begin
      case (m_state)
        MIdle:  if (ss_p) m_state = MRun;
        MRun: begin
          m_phase++;
          tick = (m_phase == Div);
          if (tick) m_phase = 0;
          if (ss_p) m_state = MPause;
          if (tick) begin
            if (m_num < MaxC) m_num++;
            else m_state = MDone;
          end
        end
        MPause: if (ss_p) m_state = MRun;
        default: ;
      endcase
    end
    // A level is accepted once the last Deb synchronised samples all disagree with it.
    for (int b = 0; b < 2; b++) begin
      m_lvl_old[b] = m_lvl[b];
      for (int i = Deb - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
      m_win[b][0] = m_sync2[b];
      all_new = 1'b1;
      for (int i = 0; i < Deb; i++) if (m_win[b][i] == m_lvl[b]) all_new = 1'b0;
      if (all_new) m_lvl[b] = !m_lvl[b];
      m_sync2[b] = m_sync1[b];
      m_sync1[b] = (b == 0) ? btn_ss : btn_clr;
    end
  endtask

  task automatic compare_model();
    check_eq("number", 32'(number), 32'(m_num));
    check_eq("running", 32'(running), 32'(m_state == MRun));
    check_eq("overflow", 32'(overflow), 32'(m_state == MDone));
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input int b, input int hold);
    if (b == 0) btn_ss = 1'b1;
    else if (b == 1) btn_clr = 1'b1;
    else begin
      btn_ss  = 1'b1;
      btn_clr = 1'b1;
    end
    idle(hold);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic bounce(input int b, input int cycles);
    for (int i = 0; i < cycles / 2; i++) begin
      if (b == 0) btn_ss = ~btn_ss;
      else btn_clr = ~btn_clr;
      idle(2);
    end
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
  endtask

  int lat;
  int n;

  initial begin
    model_reset();
    idle(3);
    check_eq("rst_number", 32'(number), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Start: latency to running, then exactly Div cycles to the first increment.
    btn_ss = 1'b1;
    lat = 0;
    while (running !== 1'b1 && lat < 30) begin
      cycle();
      lat++;
    end
    check_eq("start_latency_window", 32'(lat >= 5 && lat <= 7), 32'd1);
    n = 0;
    while (number !== 14'd1 && n < 40) begin
      cycle();
      n++;
    end
    check_eq("first_tick_cycles", 32'(n), 32'(Div));
    btn_ss = 1'b0;
    idle(20);
    check_eq("count_after_30", 32'(number), 32'd3);

    // Bounce rejection from IDLE.
    press(1, 8);
    idle(8);
    bounce(0, 20);
    idle(10);
    check_eq("bounce_no_run", 32'(running), 32'd0);

    // Pause and resume with a partial prescaler interval.
    press(0, 5);
    idle(25);
    press(0, 5);
    idle(100);
    press(0, 5);
    idle(40);

    // Saturation, then a start press that must not leave DONE.
    idle(300);
    check_eq("sat_number", 32'(number), 32'(MaxC));
    check_eq("sat_overflow", 32'(overflow), 32'd1);
    press(0, 6);
    idle(20);
    check_eq("done_holds", 32'(overflow), 32'd1);

    // Clear and start pressed together while running: clear wins.
    press(1, 6);
    idle(8);
    press(0, 6);
    idle(30);
    press(2, 6);
    idle(10);
    check_eq("clr_prio_number", 32'(number), 32'd0);
    check_eq("clr_prio_running", 32'(running), 32'd0);

    // Asynchronous reset in the middle of a tick interval.
    press(0, 6);
    n = 0;
    while (number !== 14'd7 && n < 200) begin
      cycle();
      n++;
    end
    check_eq("reached_7", 32'(number), 32'd7);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_number", 32'(number), 32'd0);
    check_eq("async_running", 32'(running), 32'd0);
    check_eq("async_overflow", 32'(overflow), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    btn_ss = 1'b1;
    lat = 0;
    while (running !== 1'b1 && lat < 30) begin
      cycle();
      lat++;
    end
    n = 0;
    while (number !== 14'd1 && n < 40) begin
      cycle();
      n++;
    end
    check_eq("post_reset_first_tick", 32'(n), 32'(Div));
    btn_ss = 1'b0;

    // Randomised mix of presses, clears, bounces and idle stretches.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1: press(0, $urandom_range(1, 12));
        2:    press(1, $urandom_range(1, 12));
        3:    bounce($urandom_range(0, 1), 2 * $urandom_range(1, 6));
        4:    press(2, $urandom_range(4, 8));
        default: ;
      endcase
      idle($urandom_range(0, 60));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
